wm_i2s_dac_tx: RTL and testbench
================================

Name: wm_i2s_dac_tx

Overview:
- I2S master transmitter for the WM8731 DAC path.
- Generates BCLK and DACLRC from the 50 MHz system clock and serialises stereo 16-bit samples onto DACDAT.
- Sits beside the codec I2C configuration block in the audio top level, replacing the tied-off BCLK/LRC/DACDAT outputs.
- Upstream logic supplies samples through a valid/ready handshake into a one-entry holding buffer.

Parameters:
- CLK_DIV, 8: CLK cycles per BCLK half-period (BCLK = 50 MHz / (2*CLK_DIV) = 3.125 MHz); legal range 2..255.
- SAMPLE_W, 16: audio word width per channel; must satisfy SAMPLE_W <= SLOT_W-1.
- SLOT_W, 32: BCLK periods per channel slot; frame length = 2*SLOT_W BCLKs (48.8 kHz at the defaults).

Ports:
- CLK  in  1  system clock, 50 MHz.
- RST  in  1  synchronous active-high reset.
- S_DATA  in  2*SAMPLE_W  stereo sample; {left, right}, left in the upper half.
- S_VALID  in  1  S_DATA valid.
- S_READY  out  1  holding buffer empty; transfer occurs when S_VALID && S_READY.
- WM_BCLK  out  1  bit clock to the codec.
- WM_DACLRC  out  1  LR clock: 0 = left slot, 1 = right slot.
- WM_DACDAT  out  1  serial DAC data, MSB first.
- WM_ADCLRC  out  1  ADC LR clock (see Optional Feature).
- WM_ADCDAT  in  1  serial ADC data (see Optional Feature).
- ADC_DATA  out  2*SAMPLE_W  captured {left, right} ADC sample.
- ADC_VALID  out  1  one-CLK pulse when ADC_DATA is updated.
- UNDERFLOW  out  1  one-CLK pulse when a frame starts with the holding buffer empty.

Behaviour:
- Reset values (while RST is high):
  - WM_BCLK=0, WM_DACLRC=0, WM_DACDAT=0, WM_ADCLRC=0.
  - ADC_DATA=0, ADC_VALID=0, UNDERFLOW=0.
  - Holding buffer empty. Divider count = 0. Bit counter = 2*SLOT_W-1.
  - S_READY = !hold_full, so it reads 1. S_VALID is ignored while RST is high.
- Divider:
  - Counts 0..CLK_DIV-1; at terminal count WM_BCLK toggles.
  - fall_tick is asserted on the CLK edge where BCLK goes 1->0; rise_tick on the edge where it goes 0->1.
- Bit counter (0..2*SLOT_W-1):
  - Advances on each fall_tick and wraps to 0.
  - WM_DACLRC = (bit_cnt >= SLOT_W); updated on the same edge as the counter.
- Slot position p = bit_cnt mod SLOT_W (I2S one-bit delay):
  - p=0: WM_DACDAT = 0.
  - p=1..SAMPLE_W: WM_DACDAT = bit (SAMPLE_W-p) of the current channel word.
  - p>SAMPLE_W: WM_DACDAT = 0.
  - All data changes happen on fall_tick only; the codec samples on the BCLK rising edge.
- Frame load, on the fall_tick where bit_cnt wraps to 0:
  - Holding buffer full: frame shift register loads the buffer and the buffer empties.
  - Holding buffer empty: frame shift register loads zeros and UNDERFLOW pulses for 1 cycle.
- Handshake:
  - S_READY = !hold_full (combinational).
  - An accept sets hold_full; S_DATA is captured on the accept edge.
  - Load and accept in the same cycle cannot occur, because load requires full and accept requires empty.
- First frame:
  - The first fall_tick comes 2*CLK_DIV cycles after RST deasserts.
  - A sample accepted before that edge plays in frame 0.
- Counters and the buffer are never cleared by anything other than RST. Reset mid-frame aborts the frame immediately and outputs take their reset values on the next edge.

Optional Feature:
- WM_I2S_ADC_RX_EN defined:
  - WM_ADCLRC mirrors WM_DACLRC.
  - WM_ADCDAT is sampled on each rise_tick at slot positions 1..SAMPLE_W, MSB first, into a left/right shift register.
  - On the fall_tick where bit_cnt wraps to 0, the captured {left, right} is copied to ADC_DATA and ADC_VALID pulses for 1 cycle. The first frame after reset is not reported.
- Not defined: WM_ADCLRC=0, ADC_DATA=0, ADC_VALID=0, WM_ADCDAT ignored.

Decomposition:
- Package wm_audio_pkg holds:
  - defaults for SAMPLE_W, SLOT_W and CLK_DIV;
  - LRC encoding constants LRC_LEFT=0 and LRC_RIGHT=1;
  - stereo sample width constant STEREO_W=2*SAMPLE_W.
- One sub-module, wm_bclk_gen: divider, WM_BCLK register, rise_tick/fall_tick outputs, parameter CLK_DIV.

Test Plan (CLK_DIV=2, SLOT_W=32, SAMPLE_W=16; BCLK period 4 CLK, frame 256 CLK):
- Reset then idle: hold RST 5 cycles -> all outputs 0, S_READY=1. First BCLK rise at cycle 2 and fall at cycle 4 after release; UNDERFLOW pulses at cycle 4 and again every 256 cycles.
- Single sample: accept {16'hA5C3, 16'h0F01} before the first fall_tick -> DACLRC=0 for 32 BCLKs then 1 for 32. DACDAT sampled on BCLK rises is 0, A5C3 MSB first, then 15 zeros; right slot is 0, 0F01, then zeros. No UNDERFLOW in that frame.
- Back-pressure: hold S_VALID=1 with incrementing data -> S_READY drops after each accept and rises exactly on the frame-load edge. Exactly one sample is consumed per 256 cycles, with no loss or duplication over 8 frames.
- Underflow mid-stream: supply samples for frames 0 and 1, none for frame 2 -> frame 2 DACDAT all zeros, one UNDERFLOW pulse at the frame 2 boundary; resuming in frame 3 plays correctly.
- Reset mid-frame: assert RST at bit_cnt=40 -> next edge BCLK, LRC and DACDAT are 0 and the buffer is empty. After release, timing restarts as in the idle case.
- WM_I2S_ADC_RX_EN: loop WM_DACDAT back to WM_ADCDAT with sample {16'h8001, 16'h7FFE} -> after the next frame boundary ADC_VALID pulses once with ADC_DATA=32'h80017FFE.

Source files
------------

// File: rtl/wm_audio_pkg.sv
// Shared constants for the WM8731 audio path: default I2S geometry and LRC encoding.
package wm_audio_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int SLOT_W_DEF   = 32;
  localparam int CLK_DIV_DEF  = 8;

  localparam logic LRC_LEFT  = 1'b0;
  localparam logic LRC_RIGHT = 1'b1;

  localparam int STEREO_W = 2 * SAMPLE_W_DEF;

endpackage

// File: rtl/wm_bclk_gen.sv
// BCLK divider: toggles the bit clock every CLK_DIV system clocks and flags the
// system-clock edges on which BCLK rises or falls.
module wm_bclk_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  output logic bclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             term;

  // Next divider count and BCLK level; ticks mark the edge where BCLK changes
  always_comb begin
    term      = (div_q == DIV_W'(CLK_DIV - 1));
    div_d     = term ? '0 : div_q + DIV_W'(1);
    bclk_d    = term ? ~bclk_q : bclk_q;
    rise_tick = term && !bclk_q;
    fall_tick = term && bclk_q;
  end

  // Divider and BCLK registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk = bclk_q;

endmodule

// File: rtl/wm_i2s_dac_tx.sv
// I2S master transmitter for the WM8731 DAC path with a one-entry sample buffer.
// Optional ADC receive path enabled by defining WM_I2S_ADC_RX_EN.
module wm_i2s_dac_tx
  import wm_audio_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int SLOT_W   = SLOT_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [2*SAMPLE_W-1:0] S_DATA,
  input  logic                  S_VALID,
  output logic                  S_READY,
  output logic                  WM_BCLK,
  output logic                  WM_DACLRC,
  output logic                  WM_DACDAT,
  output logic                  WM_ADCLRC,
  input  logic                  WM_ADCDAT,
  output logic [2*SAMPLE_W-1:0] ADC_DATA,
  output logic                  ADC_VALID,
  output logic                  UNDERFLOW
);

  localparam int FRAME_BITS = 2 * SLOT_W;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  logic rise_tick, fall_tick, wrap;

  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d, bit_nxt;
  logic                  lrc_q, lrc_d;
  logic                  dacdat_q, dacdat_d;
  logic                  hold_full_q, hold_full_d;
  logic                  underflow_q, underflow_d;
  logic [2*SAMPLE_W-1:0] hold_q, hold_d;
  logic [2*SAMPLE_W-1:0] frame_q, frame_d;

  // Bit position within the current channel slot.
  function automatic int slot_pos(input int pos);
    return (pos >= SLOT_W) ? pos - SLOT_W : pos;
  endfunction

  // Serial bit for a frame position: one-bit I2S delay, MSB first, zero padding.
  function automatic logic dac_bit(input logic [2*SAMPLE_W-1:0] frame, input int pos);
    int                    p;
    int                    idx;
    logic [2*SAMPLE_W-1:0] sh;
    p = slot_pos(pos);
    if (p < 1 || p > SAMPLE_W) return 1'b0;
    idx = SAMPLE_W - p + ((pos >= SLOT_W) ? 0 : SAMPLE_W);
    sh  = frame >> idx;
    return sh[0];
  endfunction

  wm_bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk (
    .clk       (CLK),
    .rst       (RST),
    .bclk      (WM_BCLK),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  assign S_READY = !hold_full_q;

  // Handshake, bit counter, LRC, serial data and frame load on BCLK falls
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    lrc_d       = lrc_q;
    dacdat_d    = dacdat_q;
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    frame_d     = frame_q;
    underflow_d = 1'b0;
    bit_nxt     = (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt_q + CNT_W'(1);
    wrap        = fall_tick && (bit_cnt_q == CNT_W'(FRAME_BITS - 1));

    if (S_VALID && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_d      = S_DATA;
    end

    if (fall_tick) begin
      bit_cnt_d = bit_nxt;
      lrc_d     = (int'(bit_nxt) >= SLOT_W) ? LRC_RIGHT : LRC_LEFT;
      dacdat_d  = dac_bit(frame_q, int'(bit_nxt));
      if (wrap) begin
        if (hold_full_q) begin
          frame_d     = hold_q;
          hold_full_d = 1'b0;
        end else begin
          frame_d     = '0;
          underflow_d = 1'b1;
        end
      end
    end
  end

  // Control registers, cleared by reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_cnt_q   <= CNT_W'(FRAME_BITS - 1);
      lrc_q       <= LRC_LEFT;
      dacdat_q    <= 1'b0;
      hold_full_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      lrc_q       <= lrc_d;
      dacdat_q    <= dacdat_d;
      hold_full_q <= hold_full_d;
      underflow_q <= underflow_d;
    end
  end

  // Sample payload registers; qualified by hold_full / frame load, so no reset
  always_ff @(posedge CLK) begin
    hold_q  <= hold_d;
    frame_q <= frame_d;
  end

  assign WM_DACLRC = lrc_q;
  assign WM_DACDAT = dacdat_q;
  assign UNDERFLOW = underflow_q;

`ifdef WM_I2S_ADC_RX_EN
  logic [SAMPLE_W-1:0]   adc_l_q, adc_l_d, adc_r_q, adc_r_d;
  logic [2*SAMPLE_W-1:0] adc_data_q, adc_data_d;
  logic                  adc_valid_q, adc_valid_d;
  logic                  adc_seen_q, adc_seen_d;
  int                    adc_p;

  // Shift in ADC bits on BCLK rises; publish the finished frame at each boundary
  always_comb begin
    adc_l_d     = adc_l_q;
    adc_r_d     = adc_r_q;
    adc_data_d  = adc_data_q;
    adc_valid_d = 1'b0;
    adc_seen_d  = adc_seen_q;
    adc_p       = slot_pos(int'(bit_cnt_q));
    if (rise_tick && adc_p >= 1 && adc_p <= SAMPLE_W) begin
      if (lrc_q == LRC_RIGHT) adc_r_d = {adc_r_q[SAMPLE_W-2:0], WM_ADCDAT};
      else                    adc_l_d = {adc_l_q[SAMPLE_W-2:0], WM_ADCDAT};
    end
    if (wrap) begin
      adc_seen_d = 1'b1;
      if (adc_seen_q) begin
        adc_data_d  = {adc_l_q, adc_r_q};
        adc_valid_d = 1'b1;
      end
    end
  end

  // ADC output and first-frame flag registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      adc_data_q  <= '0;
      adc_valid_q <= 1'b0;
      adc_seen_q  <= 1'b0;
    end else begin
      adc_data_q  <= adc_data_d;
      adc_valid_q <= adc_valid_d;
      adc_seen_q  <= adc_seen_d;
    end
  end

  // ADC shift registers; only read once fully refilled
  always_ff @(posedge CLK) begin
    adc_l_q <= adc_l_d;
    adc_r_q <= adc_r_d;
  end

  assign WM_ADCLRC = lrc_q;
  assign ADC_DATA  = adc_data_q;
  assign ADC_VALID = adc_valid_q;
`else
  logic unused_adc;
  assign unused_adc = WM_ADCDAT ^ rise_tick;
  assign WM_ADCLRC  = 1'b0;
  assign ADC_DATA   = '0;
  assign ADC_VALID  = 1'b0;
`endif

endmodule

// File: tb/tb_wm_i2s_dac_tx.sv
// Directed bench for wm_i2s_dac_tx at CLK_DIV=2 (BCLK = 4 CLK, frame = 256 CLK).
// ADC path is looped back from DACDAT; its checks follow WM_I2S_ADC_RX_EN.
module tb_wm_i2s_dac_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        bclk, dac_lrc, dac_dat, adc_lrc;
  logic [31:0] adc_data;
  logic        adc_valid, underflow;

  int n_chk = 0;
  int n_bad = 0;
  int n_acc = 0;
  bit stream_en = 1'b0;
  int uf_mid, rdy_mid, lrc_bad, vld_mid, nrise;

  wm_i2s_dac_tx #(
    .CLK_DIV  (2),
    .SAMPLE_W (16),
    .SLOT_W   (32)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .S_DATA    (s_data),
    .S_VALID   (s_valid),
    .S_READY   (s_ready),
    .WM_BCLK   (bclk),
    .WM_DACLRC (dac_lrc),
    .WM_DACDAT (dac_dat),
    .WM_ADCLRC (adc_lrc),
    .WM_ADCDAT (dac_dat),
    .ADC_DATA  (adc_data),
    .ADC_VALID (adc_valid),
    .UNDERFLOW (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected serial stream for one frame, position 0 at bit 63.
  function automatic logic [63:0] exp_frame(input logic [31:0] s);
    return {1'b0, s[31:16], 15'd0, 1'b0, s[15:0], 15'd0};
  endfunction

  // One CLK edge; outputs sampled 1 time unit later. Tracks accepted transfers.
  task automatic tick();
    logic acc;
    acc = s_valid && s_ready && !rst;
    @(posedge clk);
    #1;
    if (acc) begin
      n_acc++;
      if (stream_en) s_data = s_data + 32'h0001_0001;
      else           s_valid = 1'b0;
    end
  endtask

  // Runs 256 CLKs from just after a frame-load edge; last edge is the next load.
  task automatic run_frame(output logic [63:0] bits, output logic uf_end, output logic rdy_end);
    logic prev;
    bits = '0; uf_mid = 0; rdy_mid = 0; lrc_bad = 0; vld_mid = 0; nrise = 0;
    prev = bclk;
    for (int t = 1; t <= 256; t++) begin
      tick();
      if (t < 256) begin
        uf_mid  += int'(underflow);
        rdy_mid += int'(s_ready);
        vld_mid += int'(adc_valid);
      end
      if (!prev && bclk) begin
        if (nrise < 64) bits[63-nrise] = dac_dat;
        if (dac_lrc !== (nrise >= 32)) lrc_bad++;
`ifdef WM_I2S_ADC_RX_EN
        if (adc_lrc !== dac_lrc) lrc_bad++;
`else
        if (adc_lrc !== 1'b0) lrc_bad++;
`endif
        nrise++;
      end
      prev = bclk;
    end
    if (nrise != 64) lrc_bad++;
    uf_end  = underflow;
    rdy_end = s_ready;
  endtask

  // First four edges after reset release: BCLK rises at edge 2, falls at edge 4.
  task automatic startup(input string pfx, input logic exp_uf);
    tick(); chk({pfx, "_bclk_e1"}, 64'(bclk), 64'(1'b0));
    tick(); chk({pfx, "_bclk_e2"}, 64'(bclk), 64'(1'b1));
    tick(); chk({pfx, "_uf_e3"}, 64'(underflow), 64'(1'b0));
    tick();
    chk({pfx, "_bclk_e4"}, 64'(bclk), 64'(1'b0));
    chk({pfx, "_uf_e4"}, 64'(underflow), 64'(exp_uf));
    chk({pfx, "_vld_e4"}, 64'(adc_valid), 64'(1'b0));
  endtask

  task automatic frame_chk(input string pfx, input logic [31:0] smp,
                           input logic exp_uf_end, input logic exp_rdy_end);
    logic [63:0] bits;
    logic        uf_end, rdy_end;
    run_frame(bits, uf_end, rdy_end);
    chk({pfx, "_bits"}, bits, exp_frame(smp));
    chk({pfx, "_lrc"}, 64'(lrc_bad), 64'd0);
    chk({pfx, "_uf_mid"}, 64'(uf_mid), 64'd0);
    chk({pfx, "_uf_end"}, 64'(uf_end), 64'(exp_uf_end));
    chk({pfx, "_rdy_end"}, 64'(rdy_end), 64'(exp_rdy_end));
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b1; s_valid = 1'b0; s_data = '0;

    // Reset with S_VALID held high: must be ignored
    s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
    repeat (5) tick();
    chk("rst_bclk", 64'(bclk), 64'd0);
    chk("rst_lrc", 64'(dac_lrc), 64'd0);
    chk("rst_dat", 64'(dac_dat), 64'd0);
    chk("rst_adclrc", 64'(adc_lrc), 64'd0);
    chk("rst_adcdata", 64'(adc_data), 64'd0);
    chk("rst_adcvld", 64'(adc_valid), 64'd0);
    chk("rst_uf", 64'(underflow), 64'd0);
    chk("rst_ready", 64'(s_ready), 64'd1);
    s_valid = 1'b0;
    rst = 1'b0;

    // Idle: underflow at edge 4, then again 256 CLKs later
    startup("idle", 1'b1);
    frame_chk("idle_f0", 32'h0, 1'b1, 1'b1);

    // Single sample accepted before the first frame
    rst = 1'b1; repeat (3) tick(); rst = 1'b0;
    s_valid = 1'b1; s_data = 32'hA5C3_0F01;
    tick();
    chk("single_rdy_acc", 64'(s_ready), 64'd0);
    repeat (2) tick();
    tick();
    chk("single_uf_e4", 64'(underflow), 64'd0);
    chk("single_rdy_e4", 64'(s_ready), 64'd1);
    frame_chk("single_f0", 32'hA5C3_0F01, 1'b1, 1'b1);
    chk("single_vld_mid", 64'(vld_mid), 64'd0);
`ifdef WM_I2S_ADC_RX_EN
    chk("single_adc_vld", 64'(adc_valid), 64'd1);
    chk("single_adc_data", 64'(adc_data), 64'h0000_0000_A5C3_0F01);
`else
    chk("single_adc_vld", 64'(adc_valid), 64'd0);
    chk("single_adc_data", 64'(adc_data), 64'd0);
`endif

    // Back-pressure: continuous valid with incrementing data over 8 frames
    rst = 1'b1; repeat (3) tick(); rst = 1'b0;
    n_acc = 0; stream_en = 1'b1; s_valid = 1'b1; s_data = 32'h1000_2000;
    repeat (3) tick();
    tick();
    chk("bp_uf_e4", 64'(underflow), 64'd0);
    v = 32'h1000_2000;
    for (int f = 0; f < 8; f++) begin
      frame_chk($sformatf("bp_f%0d", f), v, 1'b0, 1'b1);
      chk($sformatf("bp_f%0d_rdy_mid", f), 64'(rdy_mid), 64'd0);
      v = v + 32'h0001_0001;
    end
    chk("bp_n_acc", 64'(n_acc), 64'd9);
    chk("bp_next", 64'(s_data), 64'h0000_0000_1009_2009);
    stream_en = 1'b0; s_valid = 1'b0;

    // Underflow mid-stream: frames 0,1 supplied, frame 2 empty, frame 3 resumes
    rst = 1'b1; repeat (3) tick(); rst = 1'b0;
    s_valid = 1'b1; s_data = 32'h8001_7FFE;
    repeat (4) tick();
    s_valid = 1'b1; s_data = 32'h1234_5678;
    frame_chk("uf_f0", 32'h8001_7FFE, 1'b0, 1'b1);
`ifdef WM_I2S_ADC_RX_EN
    chk("uf_adc_vld", 64'(adc_valid), 64'd1);
    chk("uf_adc_data", 64'(adc_data), 64'h0000_0000_8001_7FFE);
`else
    chk("uf_adc_vld", 64'(adc_valid), 64'd0);
    chk("uf_adc_data", 64'(adc_data), 64'd0);
`endif
    frame_chk("uf_f1", 32'h1234_5678, 1'b1, 1'b1);
    s_valid = 1'b1; s_data = 32'hCAFE_0042;
    frame_chk("uf_f2", 32'h0, 1'b0, 1'b1);
    frame_chk("uf_f3", 32'hCAFE_0042, 1'b1, 1'b1);

    // Reset mid-frame at bit_cnt 40 with the buffer full
    rst = 1'b1; repeat (3) tick(); rst = 1'b0;
    s_valid = 1'b1; s_data = 32'h0000_0100;
    repeat (4) tick();
    s_valid = 1'b1; s_data = 32'h5555_AAAA;
    repeat (162) tick();
    chk("mid_pre_bclk", 64'(bclk), 64'd1);
    chk("mid_pre_lrc", 64'(dac_lrc), 64'd1);
    chk("mid_pre_dat", 64'(dac_dat), 64'd1);
    chk("mid_pre_rdy", 64'(s_ready), 64'd0);
    rst = 1'b1;
    tick();
    chk("mid_rst_bclk", 64'(bclk), 64'd0);
    chk("mid_rst_lrc", 64'(dac_lrc), 64'd0);
    chk("mid_rst_dat", 64'(dac_dat), 64'd0);
    chk("mid_rst_rdy", 64'(s_ready), 64'd1);
    repeat (2) tick();
    rst = 1'b0;
    startup("mid", 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
